sram_sample_reader: RTL



---
 rtl/audio_sram_pkg.sv | 19 +
 rtl/sram_addr_gen.sv | 54 +++++
 rtl/sram_sample_reader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/audio_sram_pkg.sv
// audio_sram_pkg: widths, read-latency default and FSM state type shared by the
// SRAM audio record/playback paths. Rev 1.0
`default_nettype none

package audio_sram_pkg;

    localparam int unsigned c_ADDR_W  = 18;
    localparam int unsigned c_DATA_W  = 16;
    localparam int unsigned c_RD_WAIT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PRESENT = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_addr_gen.sv
// sram_addr_gen: playback address counter over an inclusive [base, end] window
// with natural modulo-2^ADDR_W increment and optional wrap to base. Rev 1.0
`default_nettype none

module sram_addr_gen
    import audio_sram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_end,
    input  logic              i_step,
    input  logic              i_loop_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_end,
    output logic              o_next_is_wrap
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_end;
    logic              w_at_end;

    // Equality-only termination lets a window cross the top of memory.
    assign w_at_end = (r_addr == r_end);

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_base <= '0;
            r_end  <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_base <= i_base;
            r_end  <= i_end;
        end else if (i_step) begin
            if (!w_at_end) begin
                r_addr <= r_addr + 1'b1;
            end else if (i_loop_en) begin
                r_addr <= r_base;
            end
        end
    end

    assign o_addr         = r_addr;
    assign o_at_end       = w_at_end;
    assign o_next_is_wrap = w_at_end & i_loop_en;

endmodule

`default_nettype wire

// File: rtl/sram_sample_reader.sv
// sram_sample_reader: streams samples from async SRAM over [base_addr, end_addr]
// onto a valid/ready stream with a fixed RD_WAIT-cycle read per sample. Rev 1.0
`default_nettype none

module sram_sample_reader
    import audio_sram_pkg::*;
#(
    parameter int RD_WAIT = c_RD_WAIT,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    localparam int              CNT_W      = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(RD_WAIT - 1);

    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_done;
    logic              r_oe_n;

    logic              w_load;
    logic              w_step;
    logic              w_capture;
    logic              w_cnt_inc;
    logic              w_valid_clr;
    logic              w_done_set;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_addr;
    logic              w_at_end;
    logic              w_next_is_wrap;

    sram_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .i_load         (w_load),
        .i_base         (base_addr),
        .i_end          (end_addr),
        .i_step         (w_step),
        .i_loop_en      (loop_en),
        .o_addr         (w_addr),
        .o_at_end       (w_at_end),
        .o_next_is_wrap (w_next_is_wrap)
    );

    assign w_xfer = r_valid & s_ready;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_capture    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_valid_clr  = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_load       = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_next_state = PRESENT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            PRESENT: begin
                // A transfer coinciding with stop is consumed; the address is
                // left alone so no further read is started.
                if (stop) begin
                    w_valid_clr  = 1'b1;
                    w_next_state = IDLE;
                end else if (w_xfer) begin
                    w_valid_clr = 1'b1;
                    if (!w_at_end || w_next_is_wrap) begin
                        w_step       = 1'b1;
                        w_next_state = SETUP;
                    end else begin
                        w_done_set   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_valid_clr  = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_oe_n  <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_inc ? r_cnt + 1'b1 : '0;
            r_done <= w_done_set;
            // OE_N tracks the state being entered, so it falls with the address load.
            r_oe_n <= (w_next_state != SETUP);
            if (w_capture) begin
                r_data  <= SRAM_DQ;
                r_valid <= 1'b1;
            end else if (w_valid_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign s_data    = r_data;
    assign s_valid   = r_valid;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign SRAM_ADDR = w_addr;
    assign SRAM_DQ   = {DATA_W{1'bz}};
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = 1'b1;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

`default_nettype wire
